abro_seq_ctrl: RTL
==================

ABRO_SEQ_CTRL -- requirements
Module: abro_seq_ctrl

Interface
REQ-001 Parameter DEPTH, default 8: number of stimulus entries in the step table (power of 2, >=2).
REQ-002 Parameter HOLD, default 4: cycles each step's a/b is driven before the check, >=1.
REQ-003 Parameter RST_CYCLES, default 2: cycles dut_reset_n is held low at run start, >=1.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low; clears all state when 0.
REQ-006 cfg_we  input  1  write enable for step table.
REQ-007 cfg_addr  input  log2(DEPTH)  step table write index.
REQ-008 cfg_data  input  7  step entry {a, b, exp_o, exp_state[3:0]}, MSB first.
REQ-009 num_steps  input  log2(DEPTH)+1  steps to run; sampled on accepted start.
REQ-010 start  input  1  begin run (level, sampled in IDLE only).
REQ-011 abort  input  1  terminate run.
REQ-012 dut_a, dut_b  output  1 each  registered stimulus to the ABRO state machine.
REQ-013 dut_reset_n  output  1  registered active-low reset to the ABRO state machine.
REQ-014 dut_o  input  1;  dut_state  input  4  observed ABRO outputs.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse at run completion.
REQ-017 pass_cnt, fail_cnt  output  log2(DEPTH)+1 each  check results of last run.
REQ-018 fail_valid  output  1;  fail_step  output  log2(DEPTH)  index of first failing step.

Function
REQ-019 FSM states: IDLE, DUT_RST, DRIVE, CHECK, DONE.
REQ-020 IDLE: dut_a=dut_b=0, dut_reset_n=1; cfg_we writes cfg_data to table[cfg_addr] on the edge.
REQ-021 cfg_we while busy=1 is ignored; table contents unchanged.
REQ-022 start=1 in IDLE with num_steps!=0: latch min(num_steps, DEPTH), clear pass_cnt/fail_cnt/fail_valid/fail_step, step index=0, go to DUT_RST.
REQ-023 start=1 in IDLE with num_steps==0: clear counters, pulse done the next cycle, stay IDLE, dut_reset_n stays 1.
REQ-024 DUT_RST: dut_reset_n=0, dut_a=dut_b=0 for exactly RST_CYCLES cycles, then DRIVE.
REQ-025 DRIVE: dut_a/dut_b = table[idx].a/b for exactly HOLD cycles, then CHECK; a/b held through CHECK.
REQ-026 CHECK (1 cycle): match = (dut_o==exp_o) and (dut_state==exp_state); match increments pass_cnt else fail_cnt.
REQ-027 First mismatch of a run sets fail_valid=1 and fail_step=idx; later mismatches do not overwrite.
REQ-028 After CHECK: idx==latched_steps-1 goes to DONE, else idx+1 and DRIVE.
REQ-029 DONE (1 cycle): done=1, dut_a=dut_b=0, then IDLE; busy deasserts with done.
REQ-030 Latency: start accepted at edge k -> done high in cycle k+1+RST_CYCLES+N*(HOLD+1), N=latched steps.
REQ-031 abort=1 in any busy state: next cycle IDLE, dut_a=dut_b=0, dut_reset_n=1, no done pulse, counters retain values; abort has priority over all transitions; abort in IDLE has no effect.
REQ-032 start while busy is ignored; start held high through DONE starts a new run from IDLE on the following cycle.
REQ-033 pass_cnt+fail_cnt==N at done; counters cannot overflow.

Reset
REQ-034 reset=0 asynchronously forces IDLE, dut_a=dut_b=0, dut_reset_n=1, busy=0, done=0, counters=0, fail_valid=0, fail_step=0.
REQ-035 Step table contents are not reset; unwritten entries are undefined until written.
REQ-036 reset mid-run aborts without done; outputs as REQ-034 immediately.

Verification
REQ-037 Load 4 steps {a,b,exp_o,exp_state}=(0,0,0,0),(1,0,0,1),(0,1,0,2),(1,1,1,3) with a correct ABRO model, start num_steps=4 -> done at cycle k+23 (defaults), pass_cnt=4, fail_cnt=0, fail_valid=0.
REQ-038 Same table with step 2 exp_state=5 -> pass_cnt=3, fail_cnt=1, fail_valid=1, fail_step=2.
REQ-039 start with num_steps=0 -> done one cycle later, busy never high, dut_reset_n stays 1.
REQ-040 abort during step 1 DRIVE -> IDLE next cycle, no done, pass_cnt=1, dut_a=dut_b=0.
REQ-041 num_steps=12 with DEPTH=8 -> exactly 8 checks, pass_cnt+fail_cnt=8.
REQ-042 reset=0 asserted mid-DUT_RST -> all outputs to REQ-034 values without waiting for clk; cfg_we during busy leaves table unchanged on next run.

Source files
------------

// File: rtl/abro_seq_ctrl.sv
// Table-driven stimulus sequencer for an ABRO state machine: resets the target,
// drives each stored {a,b} step for HOLD cycles, checks {o,state}, and tallies the results.
module abro_seq_ctrl #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned HOLD       = 4,
  parameter int unsigned RST_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_we,
  input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
  input  logic [6:0]                 cfg_data,
  input  logic [$clog2(DEPTH):0]     num_steps,
  input  logic                       start,
  input  logic                       abort,
  output logic                       dut_a,
  output logic                       dut_b,
  output logic                       dut_reset_n,
  input  logic                       dut_o,
  input  logic [3:0]                 dut_state,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH):0]     pass_cnt,
  output logic [$clog2(DEPTH):0]     fail_cnt,
  output logic                       fail_valid,
  output logic [$clog2(DEPTH)-1:0]   fail_step
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned TMAX = (HOLD > RST_CYCLES) ? HOLD : RST_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_DUT_RST, S_DRIVE, S_CHECK, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   steps_q, steps_d;
  logic [CW-1:0]   pass_q, pass_d, fail_q, fail_d;
  logic            fv_q, fv_d;
  logic [AW-1:0]   fs_q, fs_d;
  logic            dut_a_q, dut_a_d, dut_b_q, dut_b_d;
  logic            dut_reset_n_q, dut_reset_n_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic [6:0]      tbl_q [DEPTH];
  logic [6:0]      cur_c, drv_c;
  logic            last_c, match_c;

  // Entry layout: [6]=a [5]=b [4]=exp_o [3:0]=exp_state
  assign cur_c   = tbl_q[idx_q];
  assign last_c  = (CW'(idx_q) + CW'(1)) == steps_q;
  assign match_c = (dut_o == cur_c[4]) && (dut_state == cur_c[3:0]);

  // Step table: writable only while idle, never reset
  always_ff @(posedge clk) begin
    if (cfg_we && (state_q == S_IDLE)) tbl_q[cfg_addr] <= cfg_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start && (num_steps != '0)) state_d = S_DUT_RST;
      S_DUT_RST: if (tmr_q == TW'(RST_CYCLES - 1)) state_d = S_DRIVE;
      S_DRIVE:   if (tmr_q == TW'(HOLD - 1)) state_d = S_CHECK;
      S_CHECK:   state_d = last_c ? S_DONE : S_DRIVE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (abort && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  // Outputs are computed from the next state so they line up with the state they belong to
  always_comb begin
    tmr_d         = '0;
    idx_d         = idx_q;
    steps_d       = steps_q;
    pass_d        = pass_q;
    fail_d        = fail_q;
    fv_d          = fv_q;
    fs_d          = fs_q;
    done_d        = 1'b0;
    drv_c         = '0;
    dut_a_d       = 1'b0;
    dut_b_d       = 1'b0;

    if ((state_d == state_q) && ((state_q == S_DUT_RST) || (state_q == S_DRIVE)))
      tmr_d = tmr_q + TW'(1);

    if ((state_q == S_IDLE) && start) begin
      pass_d = '0;
      fail_d = '0;
      fv_d   = 1'b0;
      fs_d   = '0;
      idx_d  = '0;
      if (num_steps == '0) done_d = 1'b1;
      else steps_d = (num_steps > CW'(DEPTH)) ? CW'(DEPTH) : num_steps;
    end

    if ((state_q == S_CHECK) && !abort) begin
      if (match_c) begin
        pass_d = pass_q + CW'(1);
      end else begin
        fail_d = fail_q + CW'(1);
        if (!fv_q) begin
          fv_d = 1'b1;
          fs_d = idx_q;
        end
      end
      if (!last_c) idx_d = idx_q + AW'(1);
    end

    if (state_d == S_DONE) done_d = 1'b1;
    busy_d        = (state_d != S_IDLE);
    dut_reset_n_d = (state_d != S_DUT_RST);
    if ((state_d == S_DRIVE) || (state_d == S_CHECK)) begin
      drv_c   = tbl_q[idx_d];
      dut_a_d = drv_c[6];
      dut_b_d = drv_c[5];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmr_q         <= '0;
      idx_q         <= '0;
      steps_q       <= '0;
      pass_q        <= '0;
      fail_q        <= '0;
      fv_q          <= 1'b0;
      fs_q          <= '0;
      dut_a_q       <= 1'b0;
      dut_b_q       <= 1'b0;
      dut_reset_n_q <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      tmr_q         <= tmr_d;
      idx_q         <= idx_d;
      steps_q       <= steps_d;
      pass_q        <= pass_d;
      fail_q        <= fail_d;
      fv_q          <= fv_d;
      fs_q          <= fs_d;
      dut_a_q       <= dut_a_d;
      dut_b_q       <= dut_b_d;
      dut_reset_n_q <= dut_reset_n_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign dut_a       = dut_a_q;
  assign dut_b       = dut_b_q;
  assign dut_reset_n = dut_reset_n_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass_cnt    = pass_q;
  assign fail_cnt    = fail_q;
  assign fail_valid  = fv_q;
  assign fail_step   = fs_q;

endmodule
